// File: rtl/quad_encoder_decoder.sv
// -----------------------------------------------------------------------------
// quad_encoder_decoder
//
// Quadrature decoder for filtered encoder A/B/Z levels. It maintains a signed,
// wrapping position count at x1/x2/x4 resolution. It also reports:
//   - last counted direction
//   - one-cycle step pulses
//   - index-edge position capture
//   - step-period measurement
//   - a sticky illegal-transition flag
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enc_a/b/z       filtered encoder channels (already synchronous to clk)
//   cnt_en          enable counting (position, dir, period freeze when 0)
//   mode            00/11 = x4, 01 = x2, 10 = x1
//   dir_inv         invert count sign and reported direction
//   clr_pos         synchronous position clear (also restarts period_valid)
//   z_clr_en        clear position on index rising edge
//   err_clr         clear the sticky error flag
//   position        current count (CNT_W, two's complement)
//   dir             last counted direction, 1 = forward
//   step            one-cycle pulse per counted transition
//   index_pos       position captured at last index rising edge
//   index_valid     one-cycle pulse on index capture
//   period          clk cycles between the last two counted steps (saturating)
//   period_valid    set once a full step interval has been measured
//   err             sticky illegal-transition flag
//
// Handshake: step and index_valid are single-cycle qualifiers. The matching
// data (position/dir, index_pos) is valid in the same cycle the pulse is high.
// -----------------------------------------------------------------------------
module quad_encoder_decoder #(
    parameter int CNT_W = 32,
    parameter int PER_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_z,
    input  logic             cnt_en,
    input  logic [1:0]       mode,
    input  logic             dir_inv,
    input  logic             clr_pos,
    input  logic             z_clr_en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] position,
    output logic             dir,
    output logic             step,
    output logic [CNT_W-1:0] index_pos,
    output logic             index_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             err
);

    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    // Input stage
    logic [1:0]       ab_cur_q, ab_prev_q;
    logic             z_cur_q, z_prev_q;
    logic             sampled_q, primed_q;

    // State
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] idx_pos_q, idx_pos_d;
    logic             idx_vld_q, idx_vld_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             per_vld_q, per_vld_d;
    logic             seen_step_q, seen_step_d;
    logic             err_q, err_d;

    // Position of an {A,B} code along the forward sequence 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    logic [1:0] delta;
    logic       moved, is_fwd, is_rev, illegal;
    logic       a_changed, qualified, count, count_up, index_edge;

    // The modulo-4 distance along the sequence classifies the transition.
    // A distance of 1 is forward, 3 is reverse, and 2 (both bits flipped)
    // is illegal.
    assign delta      = gray_idx(ab_cur_q) - gray_idx(ab_prev_q);
    assign moved      = primed_q && (ab_cur_q != ab_prev_q);
    assign is_fwd     = moved && (delta == 2'd1);
    assign is_rev     = moved && (delta == 2'd3);
    assign illegal    = moved && (delta == 2'd2);
    assign a_changed  = ab_cur_q[1] ^ ab_prev_q[1];
    assign index_edge = primed_q && z_cur_q && !z_prev_q;

    always_comb begin
        qualified = 1'b0;
        case (mode)
            2'b01:   qualified = (is_fwd || is_rev) && a_changed;
            2'b10:   qualified = (is_fwd && ab_prev_q == 2'b00 && ab_cur_q == 2'b10) ||
                                 (is_rev && ab_prev_q == 2'b10 && ab_cur_q == 2'b00);
            default: qualified = is_fwd || is_rev;
        endcase
    end

    assign count    = qualified && cnt_en;
    assign count_up = is_fwd ^ dir_inv;

    always_comb begin
        pos_d       = pos_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        idx_pos_d   = idx_pos_q;
        idx_vld_d   = 1'b0;
        per_cnt_d   = per_cnt_q;
        period_d    = period_q;
        per_vld_d   = per_vld_q;
        seen_step_d = seen_step_q;
        err_d       = err_q;

        // Period counter: restarts on a step, otherwise counts while enabled.
        // A saturated counter with no step reports the stall value.
        if (count) begin
            per_cnt_d = '0;
            period_d  = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + PER_W'(1);
        end else if (cnt_en) begin
            if (per_cnt_q != PER_MAX) begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end else begin
                period_d = PER_MAX;
            end
        end

        // Lowest position priority: the count itself.
        if (count) begin
            step_d      = 1'b1;
            dir_d       = count_up;
            pos_d       = count_up ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
            per_vld_d   = per_vld_q || seen_step_q;
            seen_step_d = 1'b1;
        end

        // Index capture sees the position from before this cycle's update.
        if (index_edge) begin
            idx_pos_d = pos_q;
            idx_vld_d = 1'b1;
            if (z_clr_en) begin
                pos_d = '0;
            end
        end

        // Highest position priority below reset.
        if (clr_pos) begin
            pos_d       = '0;
            per_vld_d   = 1'b0;
            seen_step_d = 1'b0;
        end

        // Set wins over clear.
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ab_cur_q    <= 2'b00;
            ab_prev_q   <= 2'b00;
            z_cur_q     <= 1'b0;
            z_prev_q    <= 1'b0;
            sampled_q   <= 1'b0;
            primed_q    <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            idx_pos_q   <= '0;
            idx_vld_q   <= 1'b0;
            per_cnt_q   <= '0;
            period_q    <= '0;
            per_vld_q   <= 1'b0;
            seen_step_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ab_cur_q    <= {enc_a, enc_b};
            ab_prev_q   <= ab_cur_q;
            z_cur_q     <= enc_z;
            z_prev_q    <= z_cur_q;
            // Evaluation starts once both the current and previous samples
            // hold real input data rather than reset values.
            sampled_q   <= 1'b1;
            primed_q    <= sampled_q;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            idx_pos_q   <= idx_pos_d;
            idx_vld_q   <= idx_vld_d;
            per_cnt_q   <= per_cnt_d;
            period_q    <= period_d;
            per_vld_q   <= per_vld_d;
            seen_step_q <= seen_step_d;
            err_q       <= err_d;
        end
    end

    assign position     = pos_q;
    assign dir          = dir_q;
    assign step         = step_q;
    assign index_pos    = idx_pos_q;
    assign index_valid  = idx_vld_q;
    assign period       = period_q;
    assign period_valid = per_vld_q;
    assign err          = err_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
module tb_quad_encoder_decoder;

    localparam int CNT_W = 32;
    localparam int PER_W = 8;

    logic             clk;
    logic             reset;
    logic             enc_a, enc_b, enc_z;
    logic             cnt_en;
    logic [1:0]       mode;
    logic             dir_inv;
    logic             clr_pos;
    logic             z_clr_en;
    logic             err_clr;
    logic [CNT_W-1:0] position;
    logic             dir;
    logic             step;
    logic [CNT_W-1:0] index_pos;
    logic             index_valid;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             err;

    quad_encoder_decoder #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .enc_z        (enc_z),
        .cnt_en       (cnt_en),
        .mode         (mode),
        .dir_inv      (dir_inv),
        .clr_pos      (clr_pos),
        .z_clr_en     (z_clr_en),
        .err_clr      (err_clr),
        .position     (position),
        .dir          (dir),
        .step         (step),
        .index_pos    (index_pos),
        .index_valid  (index_valid),
        .period       (period),
        .period_valid (period_valid),
        .err          (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [CNT_W:0]   exp_q[$];   // {dir, position} expected at each step pulse
    logic [CNT_W-1:0] idx_q[$];   // index_pos expected at each index_valid pulse
    logic [CNT_W:0]   mon_e;
    logic [CNT_W-1:0] mon_i;
    int checks;
    int errors;

    logic [1:0] fwd_seq[4];
    logic [1:0] rev_seq[5];
    int         cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int gap);
        @(negedge clk);
        {enc_a, enc_b} = ab;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic expect_step(input logic d, input logic [CNT_W-1:0] p);
        exp_q.push_back({d, p});
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_pos = 1'b1;
        @(negedge clk);
        clr_pos = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a step/index pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (step) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step position=%0h dir=%0b expected no step", position, dir);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({dir, position} !== mon_e) begin
                        errors++;
                        $display("FAIL step_out actual dir=%0b pos=%0h expected dir=%0b pos=%0h",
                                 dir, position, mon_e[CNT_W], mon_e[CNT_W-1:0]);
                    end
                end
            end
            if (index_valid) begin
                checks++;
                if (idx_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_index index_pos=%0h expected no index", index_pos);
                end else begin
                    mon_i = idx_q.pop_front();
                    if (index_pos !== mon_i) begin
                        errors++;
                        $display("FAIL index_out actual=%0h expected=%0h", index_pos, mon_i);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        fwd_seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        rev_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        reset = 1'b1;
        enc_a = 1'b1; enc_b = 1'b1; enc_z = 1'b0;
        cnt_en = 1'b1; mode = 2'b00; dir_inv = 1'b0;
        clr_pos = 1'b0; z_clr_en = 1'b0; err_clr = 1'b0;
        idle(4);
        check("rst_position", position, 32'd0);
        check("rst_outputs", {26'd0, dir, step, index_valid, period_valid, err, 1'b0}, 32'd0);
        check("rst_index_pos", index_pos, 32'd0);
        check("rst_period", 32'(period), 32'd0);
        reset = 1'b0;

        // Priming: A=B=1 held across reset must not look like 00->11.
        idle(10);
        check("prime_position", position, 32'd0);
        check("prime_err", 32'(err), 32'd0);

        // Walk back to 00 without counting.
        cnt_en = 1'b0;
        drive_ab(2'b01, 4);
        drive_ab(2'b00, 4);
        check("walk_frozen_pos", position, 32'd0);
        cnt_en = 1'b1;

        // x4 forward, 12 transitions, 20 clk apart.
        for (int k = 0; k < 12; k++) begin
            expect_step(1'b1, CNT_W'(k + 1));
            drive_ab(fwd_seq[(k + 1) % 4], 20);
        end
        idle(3);
        check("x4_fwd_pos", position, 32'd12);
        check("x4_fwd_dir", 32'(dir), 32'd1);
        check("x4_period", 32'(period), 32'd20);
        check("x4_period_valid", 32'(period_valid), 32'd1);

        // x4 reverse, 5 transitions.
        for (int k = 0; k < 5; k++) begin
            expect_step(1'b0, CNT_W'(11 - k));
            drive_ab(rev_seq[k], 5);
        end
        idle(3);
        check("x4_rev_pos", position, 32'd7);
        check("x4_rev_dir", 32'(dir), 32'd0);
        expect_step(1'b1, CNT_W'(8));
        drive_ab(2'b00, 5);
        pulse_clr();
        idle(2);
        check("clr_pos", position, 32'd0);
        check("clr_period_valid", 32'(period_valid), 32'd0);

        // x2 forward: counts on the transitions where A changes.
        mode = 2'b01;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if ((k % 4) == 0 || (k % 4) == 2) begin
                cnt++;
                expect_step(1'b1, CNT_W'(cnt));
            end
            drive_ab(fwd_seq[(k + 1) % 4], 5);
        end
        idle(3);
        check("x2_fwd_pos", position, 32'd6);
        pulse_clr();

        // x1 forward: counts only 00->10.
        mode = 2'b10;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if ((k % 4) == 0) begin
                cnt++;
                expect_step(1'b1, CNT_W'(cnt));
            end
            drive_ab(fwd_seq[(k + 1) % 4], 5);
        end
        idle(3);
        check("x1_fwd_pos", position, 32'd3);
        pulse_clr();
        idle(2);

        // x1 reverse from 0: only 10->00 counts, wrapping to all ones.
        for (int k = 0; k < 4; k++) begin
            if (k == 3) expect_step(1'b0, '1);
            drive_ab(rev_seq[k], 5);
        end
        idle(3);
        check("x1_wrap_pos", position, 32'hFFFF_FFFF);
        check("x1_wrap_dir", 32'(dir), 32'd0);

        // Illegal 00->11.
        drive_ab(2'b11, 5);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_pos", position, 32'hFFFF_FFFF);
        drive_ab(2'b10, 5);
        // Illegal 10->01 with err_clr in the evaluation cycle: set wins.
        drive_ab(2'b01, 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        idle(3);
        check("err_set_wins", 32'(err), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        idle(2);
        check("err_clr_alone", 32'(err), 32'd0);
        check("err_pos_kept", position, 32'hFFFF_FFFF);
        drive_ab(2'b00, 5);
        pulse_clr();
        mode = 2'b00;

        // Advance to 37, then index edge with z_clr_en coincident with a count.
        for (int k = 0; k < 37; k++) begin
            expect_step(1'b1, CNT_W'(k + 1));
            drive_ab(fwd_seq[(k + 1) % 4], 3);
        end
        idle(3);
        check("idx_pre_pos", position, 32'd37);
        z_clr_en = 1'b1;
        expect_step(1'b1, CNT_W'(0));
        idx_q.push_back(CNT_W'(37));
        @(negedge clk);
        enc_z = 1'b1;
        {enc_a, enc_b} = 2'b11;
        idle(5);
        enc_z = 1'b0;
        idle(3);
        check("idx_clr_pos", position, 32'd0);

        // Same again without the index clear: the count goes through.
        z_clr_en = 1'b0;
        expect_step(1'b1, CNT_W'(1));
        idx_q.push_back(CNT_W'(0));
        @(negedge clk);
        enc_z = 1'b1;
        {enc_a, enc_b} = 2'b01;
        idle(5);
        enc_z = 1'b0;
        idle(3);
        check("idx_noclr_pos", position, 32'd1);

        // clr_pos coincident with a count.
        expect_step(1'b1, CNT_W'(0));
        drive_ab(2'b00, 1);
        @(negedge clk); clr_pos = 1'b1;
        @(negedge clk); clr_pos = 1'b0;
        idle(3);
        check("clr_coinc_pos", position, 32'd0);
        check("clr_coinc_pvalid", 32'(period_valid), 32'd0);

        // Stall: no steps for more than 2^PER_W cycles.
        idle((1 << PER_W) + 15);
        check("stall_period", 32'(period), 32'((1 << PER_W) - 1));

        // cnt_en = 0: four transitions, nothing counted.
        cnt_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_ab(fwd_seq[(k + 1) % 4], 5);
        end
        idle(3);
        check("frozen_pos", position, 32'd0);
        cnt_en = 1'b1;
        idle(5);

        check("steps_left", 32'(exp_q.size()), 32'd0);
        check("index_left", 32'(idx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
- Quadrature decoder placed directly downstream of the per-channel encoder low-pass filters.
- Consumes the filtered A/B/Z levels and maintains a signed position count with x1/x2/x4 resolution.
- Also reports direction, step pulses, index capture, step-period measurement and an illegal-transition error flag for the motion-control register block.

Parameters:
CNT_W, 32, width of the position counter (two's complement, wraps modulo 2^CNT_W)
PER_W, 20, width of the step-period counter in clk cycles (saturating)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
enc_a  in  1  filtered channel A (sig_filter of A-channel LPF)
enc_b  in  1  filtered channel B
enc_z  in  1  filtered index channel
cnt_en  in  1  1 = counting enabled
mode  in  2  00/11 = x4, 01 = x2, 10 = x1
dir_inv  in  1  1 = invert count sign and dir
clr_pos  in  1  synchronous position clear
z_clr_en  in  1  1 = clear position on index rising edge
err_clr  in  1  clear sticky error
position  out  CNT_W  current count
dir  out  1  last counted direction (1 = forward)
step  out  1  one-cycle pulse per counted transition
index_pos  out  CNT_W  position captured at last index rising edge
index_valid  out  1  one-cycle pulse on index capture
period  out  PER_W  clk cycles between last two counted steps
period_valid  out  1  1 once a full step interval has been measured
err  out  1  sticky illegal-transition flag

Behaviour:
- Reset (sync, active-high): all outputs 0; internal ab_prev = 00; z_prev = 0; per_cnt = 0; primed = 0.
- Input stage:
  - Each clk, {enc_a, enc_b} registers into ab_cur and enc_z into z_cur.
  - ab_prev <= ab_cur.
  - primed sets one cycle after the first post-reset sample. No transition or index edge is evaluated while primed = 0, so reset never produces a spurious count.
- Transition decode ({A,B}):
  - Forward sequence: 00→10→11→01→00. Reverse sequence: the opposite order.
  - ab_cur == ab_prev: no event.
  - Both bits differ: illegal. err <= 1; no count; dir unchanged.
- Count qualification:
  - x4: every legal transition.
  - x2: legal transitions where A changes.
  - x1: only 00→10 (+1) and 10→00 (−1).
  - Qualified and cnt_en = 1: step = 1 for one cycle; position ± 1; dir updated. dir_inv negates both the increment and dir.
- Latency: an input edge at the port is seen in position/step/dir on the 2nd rising clk edge after it is sampled. Wrap: 2^CNT_W−1 +1 → 0; 0 −1 → all ones.
- Priority on position, highest first:
  1. reset
  2. clr_pos
  3. index clear (z_clr_en & index edge)
  4. count
  - Any clear in the same cycle as a count yields position = 0; step still pulses.
- Index:
  - z_cur & ~z_prev with primed = 1 → index_pos <= position value before that cycle's update; index_valid pulses one cycle.
  - Index is independent of cnt_en.
- Period:
  - per_cnt increments each cycle while cnt_en = 1, saturating at 2^PER_W−1.
  - On a counted step: period <= per_cnt + 1 (saturated); per_cnt <= 0.
  - period_valid sets on the 2nd counted step after reset or clr_pos and stays set until reset or clr_pos.
  - If per_cnt saturates with no step: period <= 2^PER_W−1 (stall indication).
- Error: err is sticky. err_clr clears it. If an illegal transition and err_clr occur in the same cycle, err = 1 (set wins).
- cnt_en = 0:
  - Frozen: position, dir, per_cnt, period.
  - Continue tracking: ab_prev, err detection, index capture.
  - No step pulses.
- mode change mid-run: takes effect on the next transition; no position adjustment.

Test Plan:
- Reset then hold A=B=1: after release, position = 0, step never pulses, err = 0 (priming check).
- x4, forward, 3 full cycles (12 transitions, 20 clk apart) → position = 12, dir = 1, 12 step pulses, period = 20 with period_valid = 1. Then reverse 5 transitions → position = 7, dir = 0.
- Same 12 forward transitions in x2 → 6; in x1 → 3; x1 reverse from 0 over one cycle → position = all ones (wrap −1).
- Force 00→11 → err = 1, position unchanged. Pulse err_clr together with another 10→01 → err stays 1. err_clr alone → err = 0.
- z_clr_en = 1, position = 37, index rising edge coincident with a forward count → index_pos = 37, index_valid pulse, position = 0. Repeat with z_clr_en = 0 → position increments.
- clr_pos coincident with count → position = 0, period_valid = 0. No step for 2^PER_W cycles → period = 2^PER_W−1. cnt_en = 0 during 4 transitions → position frozen, no step.
